// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
// Drives an HC-SR04-style ultrasonic sensor and feeds the LCD distance path.
// Each cycle of operation fires a trigger pulse, times the echo pulse width,
// converts it to centimetres and writes the 16-bit result as two bytes
// (high, then low) into the display's distance FIFO.
//
// Optional build macro: ULTRASONIC_AVG_EN
//   When defined, valid results are smoothed with a 4-entry moving average
//   before emission (one extra cycle between measurement and emit).
//   When undefined, each raw measurement is emitted directly.
//
// Ports:
//   clk            core clock
//   rst            synchronous reset, active-high
//   echo           sensor echo (asynchronous, synchronized internally)
//   trig           sensor trigger
//   dis_fifo_full  downstream FIFO full
//   dis_data       byte to FIFO
//   dis_data_wr    FIFO write strobe, one cycle per byte
//   distance       last emitted distance
//   distance_valid one-cycle pulse when distance updates
//   drop_cnt       saturating count of results dropped on a full FIFO
module ultrasonic_ranger #(
  parameter int CLK_FREQ_MHZ    = 50,
  parameter int TRIG_US         = 10,
  parameter int US_PER_CM       = 58,
  parameter int PERIOD_US       = 60000,
  parameter int RISE_TIMEOUT_US = 30000,
  parameter int MAX_CM          = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  input  logic        dis_fifo_full,
  output logic [7:0]  dis_data,
  output logic        dis_data_wr,
  output logic [15:0] distance,
  output logic        distance_valid,
  output logic [7:0]  drop_cnt
);

  localparam int PW   = $clog2(CLK_FREQ_MHZ + 1);
  localparam int TMAX = (TRIG_US > RISE_TIMEOUT_US) ? TRIG_US : RISE_TIMEOUT_US;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PCW  = $clog2(PERIOD_US + 1);
  localparam int UW   = $clog2(US_PER_CM + 1);
  localparam logic [15:0] OOR = 16'h0FFF;  // out-of-range / timeout marker

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_AVG, S_EMIT_HI, S_EMIT_LO
  } state_t;

  // State entered once a raw result is known.
`ifdef ULTRASONIC_AVG_EN
  localparam state_t S_POST = S_AVG;
`else
  localparam state_t S_POST = S_EMIT_HI;
`endif

  state_t          state_q;
  logic [PW-1:0]   presc_q;
  logic [PCW-1:0]  period_cnt_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [UW-1:0]   us_cnt_q;
  logic [15:0]     cm_cnt_q;
  logic [15:0]     meas_q;
  logic            first_q;
  logic            trig_q;
  logic [7:0]      dis_data_q;
  logic            dis_data_wr_q;
  logic [15:0]     distance_q;
  logic            distance_valid_q;
  logic [7:0]      drop_cnt_q;

  // Echo synchronizer. Deliberately not reset so that the synchronized copy
  // keeps tracking the real pin level through a reset; IDLE relies on it to
  // hold off a new trigger while the sensor is still echoing.
  logic echo_m_q, echo_s_q, echo_p_q;
  always_ff @(posedge clk) begin
    echo_m_q <= echo;
    echo_s_q <= echo_m_q;
    echo_p_q <= echo_s_q;
  end

  logic echo_rise;
  assign echo_rise = echo_s_q & ~echo_p_q;

  logic us_tick;
  assign us_tick = (presc_q == PW'(CLK_FREQ_MHZ - 1));

  logic [15:0] emit_val;

`ifdef ULTRASONIC_AVG_EN
  logic [15:0] hist_q [4];
  logic        hist_vld_q;
  logic [15:0] avg_q;
  logic [17:0] sum_d;

  // Sum of the history as it will look once the new sample is shifted in.
  // The first valid sample stands in for all four entries.
  always_comb begin
    sum_d = {meas_q, 2'b00};
    if (hist_vld_q)
      sum_d = {2'b00, meas_q} + {2'b00, hist_q[0]} +
              {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
  end

  assign emit_val = avg_q;
`else
  assign emit_val = meas_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      presc_q          <= '0;
      period_cnt_q     <= '0;
      tick_cnt_q       <= '0;
      us_cnt_q         <= '0;
      cm_cnt_q         <= '0;
      meas_q           <= '0;
      first_q          <= 1'b1;
      trig_q           <= 1'b0;
      dis_data_q       <= '0;
      dis_data_wr_q    <= 1'b0;
      distance_q       <= '0;
      distance_valid_q <= 1'b0;
      drop_cnt_q       <= '0;
`ifdef ULTRASONIC_AVG_EN
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      hist_vld_q       <= 1'b0;
      avg_q            <= '0;
`endif
    end else begin
      dis_data_wr_q    <= 1'b0;
      distance_valid_q <= 1'b0;
      presc_q          <= us_tick ? '0 : presc_q + PW'(1);
      if (us_tick && period_cnt_q != PCW'(PERIOD_US))
        period_cnt_q <= period_cnt_q + PCW'(1);

      case (state_q)
        S_IDLE: begin
          if ((first_q || period_cnt_q == PCW'(PERIOD_US)) && !echo_s_q) begin
            state_q      <= S_TRIG;
            trig_q       <= 1'b1;
            first_q      <= 1'b0;
            period_cnt_q <= '0;
            tick_cnt_q   <= '0;
            // Re-phase the prescaler so the trigger spans exactly TRIG_US
            // whole microseconds and the period counts from trigger start.
            presc_q      <= '0;
          end
        end

        S_TRIG: begin
          if (us_tick) begin
            if (tick_cnt_q == TW'(TRIG_US - 1)) begin
              trig_q     <= 1'b0;
              tick_cnt_q <= '0;
              state_q    <= S_WAIT_RISE;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
        end

        S_WAIT_RISE: begin
          if (echo_rise) begin
            us_cnt_q <= '0;
            cm_cnt_q <= '0;
            state_q  <= S_MEASURE;
          end else if (us_tick) begin
            if (tick_cnt_q == TW'(RISE_TIMEOUT_US - 1)) begin
              meas_q  <= OOR;
              state_q <= S_POST;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
        end

        S_MEASURE: begin
          if (!echo_s_q) begin
            meas_q  <= cm_cnt_q;
            state_q <= S_POST;
          end else if (cm_cnt_q == 16'(MAX_CM + 1)) begin
            // Saturate without waiting for the echo to end.
            meas_q  <= OOR;
            state_q <= S_POST;
          end else if (us_tick) begin
            if (us_cnt_q == UW'(US_PER_CM - 1)) begin
              us_cnt_q <= '0;
              cm_cnt_q <= cm_cnt_q + 16'd1;
            end else begin
              us_cnt_q <= us_cnt_q + UW'(1);
            end
          end
        end

`ifdef ULTRASONIC_AVG_EN
        S_AVG: begin
          if (meas_q == OOR) begin
            avg_q <= meas_q;  // markers bypass and never pollute history
          end else begin
            avg_q      <= sum_d[17:2];
            hist_vld_q <= 1'b1;
            hist_q[0]  <= meas_q;
            if (hist_vld_q) begin
              hist_q[1] <= hist_q[0];
              hist_q[2] <= hist_q[1];
              hist_q[3] <= hist_q[2];
            end else begin
              hist_q[1] <= meas_q;
              hist_q[2] <= meas_q;
              hist_q[3] <= meas_q;
            end
          end
          state_q <= S_EMIT_HI;
        end
`endif

        S_EMIT_HI: begin
          // The full check happens once per result: either both bytes go
          // out or neither does, so the display never sees half a pair.
          if (dis_fifo_full) begin
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            state_q <= S_IDLE;
          end else begin
            dis_data_q    <= emit_val[15:8];
            dis_data_wr_q <= 1'b1;
            state_q       <= S_EMIT_LO;
          end
        end

        S_EMIT_LO: begin
          dis_data_q       <= emit_val[7:0];
          dis_data_wr_q    <= 1'b1;
          distance_q       <= emit_val;
          distance_valid_q <= 1'b1;
          state_q          <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trig           = trig_q;
  assign dis_data       = dis_data_q;
  assign dis_data_wr    = dis_data_wr_q;
  assign distance       = distance_q;
  assign distance_valid = distance_valid_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with shortened timing parameters.
// Expected results are pushed to a scoreboard queue when the echo is driven
// and compared when the byte pair appears on the FIFO write port.
module tb_ultrasonic_ranger;

  localparam int F     = 2;    // CLK_FREQ_MHZ
  localparam int TRIG  = 3;
  localparam int UPC   = 5;
  localparam int PER   = 400;
  localparam int RTO   = 150;
  localparam int MAXCM = 20;
  localparam logic [15:0] OOR = 16'h0FFF;

  logic        gclk = 1'b0;
  logic        rst = 1'b1;
  logic        echo = 1'b0;
  logic        trig;
  logic        dis_fifo_full = 1'b0;
  logic [7:0]  dis_data;
  logic        dis_data_wr;
  logic [15:0] distance;
  logic        distance_valid;
  logic [7:0]  drop_cnt;

  ultrasonic_ranger #(
    .CLK_FREQ_MHZ(F), .TRIG_US(TRIG), .US_PER_CM(UPC),
    .PERIOD_US(PER), .RISE_TIMEOUT_US(RTO), .MAX_CM(MAXCM)
  ) dut (
    .clk(gclk), .rst(rst), .echo(echo), .trig(trig),
    .dis_fifo_full(dis_fifo_full), .dis_data(dis_data),
    .dis_data_wr(dis_data_wr), .distance(distance),
    .distance_valid(distance_valid), .drop_cnt(drop_cnt)
  );

  always #5 gclk = ~gclk;

  int n_chk = 0, n_fail = 0;
  logic [15:0] sb [$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  // ---------------- reference model of the emitted value
`ifdef ULTRASONIC_AVG_EN
  logic [15:0] mh [4];
  bit          mv = 1'b0;
`endif
  task automatic model(input logic [15:0] raw, output logic [15:0] e);
    e = raw;
`ifdef ULTRASONIC_AVG_EN
    if (raw != OOR) begin
      if (!mv) begin
        for (int i = 0; i < 4; i++) mh[i] = raw;
        mv = 1'b1;
      end else begin
        mh[3] = mh[2]; mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = raw;
      end
      e = 16'((32'(mh[0]) + 32'(mh[1]) + 32'(mh[2]) + 32'(mh[3])) >> 2);
    end
`endif
  endtask

  // ---------------- monitor
  int cyc = 0;
  always @(posedge gclk) cyc++;

  int   rise_cyc = 0, fall_cyc = 0, lo_cyc = 0, n_rise = 0, n_wr = 0, wr_run = 0;
  logic prev_trig = 1'b0, prev_wr = 1'b0;
  logic [7:0] hi_byte = '0;

  always @(negedge gclk) begin
    if (rst) begin
      prev_trig = 1'b0;
      prev_wr   = 1'b0;
      wr_run    = 0;
    end else begin
      if (trig && !prev_trig) begin
        rise_cyc = cyc;
        n_rise++;
      end
      if (!trig && prev_trig) begin
        fall_cyc = cyc;
        chk("trig_width", cyc - rise_cyc, TRIG * F);
      end
      if (distance_valid) chk("valid_with_wr", dis_data_wr, 1);
      if (dis_data_wr) begin
        n_wr++;
        wr_run++;
        if (!prev_wr) begin
          hi_byte = dis_data;
          chk("valid_on_hi", distance_valid, 0);
        end else begin
          logic [15:0] e;
          chk("sb_has_entry", int'(sb.size() != 0), 1);
          e = (sb.size() != 0) ? sb.pop_front() : 16'hDEAD;
          chk("hi_byte", hi_byte, e[15:8]);
          chk("lo_byte", dis_data, e[7:0]);
          chk("distance", distance, e);
          chk("valid_on_lo", distance_valid, 1);
          lo_cyc = cyc;
        end
      end else if (prev_wr) begin
        chk("wr_run_len", wr_run, 2);
        wr_run = 0;
      end
      prev_trig = trig;
      prev_wr   = dis_data_wr;
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge gclk); #1;
  endtask

  task automatic wait_trig_fall();
    int n = 0;
    while (!trig && n < 5000) begin step(); n++; end
    while (trig && n < 5000) begin step(); n++; end
    chk("trig_cycle_seen", int'(n < 5000), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin step(); n++; end
    repeat (4) step();
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic do_meas(input int cm, input bit drop);
    logic [15:0] e;
    wait_trig_fall();
    repeat (10) step();
    echo = 1'b1;
    model(16'(cm), e);
    if (!drop) sb.push_back(e);
    repeat ((cm * UPC + UPC / 2) * F) step();
    echo = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int w0, r0, rc, n;
    logic [15:0] e;

    // reset state
    repeat (3) step();
    chk("rst_trig", trig, 0);
    chk("rst_data", dis_data, 0);
    chk("rst_wr", dis_data_wr, 0);
    chk("rst_distance", distance, 0);
    chk("rst_valid", distance_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    step();
    chk("trig_first_cycle", trig, 1);

    // normal measurements including both ends of the valid range
    do_meas(7, 1'b0);     drain();
    do_meas(0, 1'b0);     drain();
    do_meas(MAXCM, 1'b0); drain();

    // echo held high: saturates at MAX_CM+1 while echo still high, and no
    // new trigger is issued until the echo finally drops
    wait_trig_fall();
    repeat (10) step();
    echo = 1'b1;
    sb.push_back(OOR);
    r0 = n_rise;
    repeat (1000) step();
    chk("sat_emitted_while_high", sb.size(), 0);
    chk("no_trig_while_echo", n_rise - r0, 0);
    echo = 1'b0;
    n = 0;
    while (n_rise == r0 && n < 10) begin step(); n++; end
    chk("retrig_after_echo_low", n_rise - r0, 1);

    // echo never rises: timeout marker, then period-spaced retrigger
    wait_trig_fall();
    rc = rise_cyc;
    model(OOR, e);
    sb.push_back(e);
    drain();
    chk("timeout_latency", int'(lo_cyc - fall_cyc >= RTO * F &&
                                lo_cyc - fall_cyc <= RTO * F + 6), 1);
    r0 = n_rise;
    n = 0;
    while (n_rise == r0 && n < 2000) begin step(); n++; end
    chk("period_retrig", int'(n_rise != r0 && rise_cyc - rc >= PER * F &&
                              rise_cyc - rc <= PER * F + 2), 1);

    // FIFO full during EMIT_HI: whole result dropped
    dis_fifo_full = 1'b1;
    w0 = n_wr;
    do_meas(5, 1'b1);
    repeat (20) step();
    chk("drop_no_write", n_wr - w0, 0);
    chk("drop_cnt_1", drop_cnt, 1);
    dis_fifo_full = 1'b0;

    // FIFO goes full after the high byte: pair still completes
    do_meas(9, 1'b0);
    n = 0;
    while (!dis_data_wr && n < 100) begin step(); n++; end
    dis_fifo_full = 1'b1;
    repeat (3) step();
    dis_fifo_full = 1'b0;
    drain();
    chk("drop_cnt_still_1", drop_cnt, 1);

    // reset during MEASURE: no write, fresh trigger once echo is low
    wait_trig_fall();
    repeat (10) step();
    echo = 1'b1;
    repeat (30) step();
    w0 = n_wr;
    rst = 1'b1;
    step();
    chk("rst_mid_trig", trig, 0);
    chk("rst_mid_wr", dis_data_wr, 0);
    repeat (2) step();
    rst = 1'b0;
`ifdef ULTRASONIC_AVG_EN
    mv = 1'b0;
`endif
    r0 = n_rise;
    repeat (40) step();
    chk("rst_no_write", n_wr - w0, 0);
    chk("rst_no_trig_echo_high", n_rise - r0, 0);
    chk("rst_drop_clr", drop_cnt, 0);
    chk("rst_distance_clr", distance, 0);
    echo = 1'b0;
    n = 0;
    while (n_rise == r0 && n < 8) begin step(); n++; end
    chk("rst_fresh_trig", n_rise - r0, 1);

    // recovery after reset
    do_meas(13, 1'b0); drain();

    chk("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
